// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, reads instruction memory and buffers words in a 2-entry queue for decode.
// Optional halt-on-HALT_WORD behaviour is compiled in with `define FETCH_HALT_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] IM_Address,
  input  logic [31:0] IM_Instruction,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstruction,
  output logic [31:0] OutPC,
  output logic [31:0] OutPCPlus4,
  output logic        Halted
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [0:0]  state_q, state_d;
  logic [31:0] e0_pc_q, e0_pc_d, e0_instr_q, e0_instr_d;
  logic [31:0] e1_pc_q, e1_pc_d, e1_instr_q, e1_instr_d;

  logic pop;
  logic push;

  assign OutValid       = (count_q != 2'd0);
  assign pop            = OutValid & OutReady;
  assign push           = (state_q == ST_RUN) & ((count_q < 2'd2) | pop) & ~Redirect;
  assign IM_Address     = pc_q;
  assign OutInstruction = OutValid ? e0_instr_q : '0;
  assign OutPC          = OutValid ? e0_pc_q : '0;
  assign OutPCPlus4     = OutValid ? (e0_pc_q + 32'd4) : '0;
  assign Halted         = HALT_EN && (state_q == ST_HALT);

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    state_d    = state_q;
    e0_pc_d    = e0_pc_q;
    e0_instr_d = e0_instr_q;
    e1_pc_d    = e1_pc_q;
    e1_instr_d = e1_instr_q;

    if (Redirect) begin
      // Redirect wins over any pop this cycle: the head is discarded, not accepted.
      count_d = 2'd0;
      pc_d    = RedirectPC & ~32'h3;
      state_d = ST_RUN;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
        if (HALT_EN && (IM_Instruction == HALT_WORD))
          state_d = ST_HALT;
      end
      case ({push, pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            e0_pc_d    = e1_pc_q;
            e0_instr_d = e1_instr_q;
            e1_pc_d    = pc_q;
            e1_instr_d = IM_Instruction;
          end else begin
            e0_pc_d    = pc_q;
            e0_instr_d = IM_Instruction;
          end
        end
        2'b01: begin
          e0_pc_d    = e1_pc_q;
          e0_instr_d = e1_instr_q;
          count_d    = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_pc_d    = pc_q;
            e0_instr_d = IM_Instruction;
          end else begin
            e1_pc_d    = pc_q;
            e1_instr_d = IM_Instruction;
          end
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      state_q    <= ST_RUN;
      e0_pc_q    <= '0;
      e0_instr_q <= '0;
      e1_pc_q    <= '0;
      e1_instr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      state_q    <= state_d;
      e0_pc_q    <= e0_pc_d;
      e0_instr_q <= e0_instr_d;
      e1_pc_q    <= e1_pc_d;
      e1_instr_q <= e1_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory word i holds i*3, one instance at RESET_PC 0, one near the wrap point.
// The halt sequence expects different results depending on whether FETCH_HALT_EN is defined.
module tb_fetch_sequencer;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        OutReady;
  logic        halt_mode;

  logic [31:0] addr0, im0, instr0, pc0, pc40;
  logic        valid0, halted0;
  logic [31:0] addr1, im1, instr1, pc1, pc41;
  logic        valid1, halted1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 Clk = ~Clk;

  always_comb begin
    if (halt_mode && addr0[31:2] == 30'd3) im0 = HALT;
    else                                    im0 = {2'b00, addr0[31:2]} * 32'd3;
    im1 = {2'b00, addr1[31:2]} * 32'd3;
  end

  fetch_sequencer #(.RESET_PC(32'h00000000), .HALT_WORD(HALT)) dut0 (
    .Clk(Clk), .Reset(Reset), .IM_Address(addr0), .IM_Instruction(im0),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .OutValid(valid0), .OutReady(OutReady),
    .OutInstruction(instr0), .OutPC(pc0), .OutPCPlus4(pc40), .Halted(halted0));

  fetch_sequencer #(.RESET_PC(32'hFFFFFFF8), .HALT_WORD(HALT)) dut1 (
    .Clk(Clk), .Reset(Reset), .IM_Address(addr1), .IM_Instruction(im1),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .OutValid(valid1), .OutReady(OutReady),
    .OutInstruction(instr1), .OutPC(pc1), .OutPCPlus4(pc41), .Halted(halted1));

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_head0(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] ins, input logic [31:0] addr);
    chk({tag, ".valid"}, {31'd0, valid0}, {31'd0, v});
    chk({tag, ".pc"}, pc0, v ? pc : 32'd0);
    chk({tag, ".instr"}, instr0, v ? ins : 32'd0);
    chk({tag, ".pc4"}, pc40, v ? pc + 32'd4 : 32'd0);
    chk({tag, ".addr"}, addr0, addr);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    #2;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Redirect = 1'b0; RedirectPC = '0; OutReady = 1'b1; halt_mode = 1'b0;

    vecs[0]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h00, 32'd0,  32'h04};
    vecs[1]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h04, 32'd3,  32'h08};
    vecs[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h08, 32'd6,  32'h0C};
    vecs[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 32'd6,  32'h10};
    vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 32'd6,  32'h10};
    vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 32'd6,  32'h10};
    vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h0C, 32'd9,  32'h14};
    vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 32'd12, 32'h18};
    vecs[8]  = '{1'b1, 32'h43, 1'b1, 1'b0, 32'h00, 32'd0,  32'h40};
    vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'd48, 32'h44};
    vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h44, 32'd51, 32'h48};

    #12;
    chk_head0("rst0", 1'b0, 32'h0, 32'h0, 32'h0);
    chk("rst0.halted", {31'd0, halted0}, 32'd0);
    chk("rst1.addr", addr1, 32'hFFFFFFF8);
    chk("rst1.valid", {31'd0, valid1}, 32'd0);

    // Wrap-around on the second instance.
    @(negedge Clk);
    Reset = 1'b0;
    step();
    chk("wrap.pc_a", pc1, 32'hFFFFFFF8);
    chk("wrap.pc4_a", pc41, 32'hFFFFFFFC);
    step();
    chk("wrap.pc_b", pc1, 32'hFFFFFFFC);
    chk("wrap.pc4_b", pc41, 32'h00000000);
    chk("wrap.instr_b", instr1, 32'h3FFFFFFF * 32'd3);
    step();
    chk("wrap.pc_c", pc1, 32'h00000000);
    chk("wrap.instr_c", instr1, 32'd0);
    chk("wrap.valid_c", {31'd0, valid1}, 32'd1);

    // Table: streaming, stall to full, release, redirect while full.
    do_reset();
    for (int unsigned i = 0; i < 11; i++) begin
      Redirect = vecs[i].redirect;
      RedirectPC = vecs[i].rpc;
      OutReady = vecs[i].ready;
      step();
      chk_head0($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                vecs[i].exp_instr, vecs[i].exp_addr);
    end
    Redirect = 1'b0;

    // Stall right after reset: queue saturates with PC 0 at the head.
    OutReady = 1'b0;
    do_reset();
    step();
    chk_head0("stall1", 1'b1, 32'h0, 32'd0, 32'h4);
    for (int unsigned i = 2; i <= 5; i++) begin
      step();
      chk_head0($sformatf("stall%0d", i), 1'b1, 32'h0, 32'd0, 32'h8);
    end
    OutReady = 1'b1;
    step();
    chk_head0("drain1", 1'b1, 32'h4, 32'd3, 32'hC);
    step();
    chk_head0("drain2", 1'b1, 32'h8, 32'd6, 32'h10);

    // Async reset between edges with a full queue.
    OutReady = 1'b0;
    step();
    step();
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("arst.valid", {31'd0, valid0}, 32'd0);
    chk("arst.addr0", addr0, 32'h0);
    chk("arst.instr", instr0, 32'h0);
    chk("arst.addr1", addr1, 32'hFFFFFFF8);

    // HALT_WORD at word 3.
    halt_mode = 1'b1;
    OutReady = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    step(); chk_head0("halt1", 1'b1, 32'h0, 32'd0, 32'h4);
    step(); chk_head0("halt2", 1'b1, 32'h4, 32'd3, 32'h8);
    step(); chk_head0("halt3", 1'b1, 32'h8, 32'd6, 32'hC);
    step(); chk_head0("halt4", 1'b1, 32'hC, HALT, 32'h10);
`ifdef FETCH_HALT_EN
    chk("halt4.halted", {31'd0, halted0}, 32'd1);
    step(); chk_head0("halt5", 1'b0, 32'h0, 32'h0, 32'h10);
    chk("halt5.halted", {31'd0, halted0}, 32'd1);
    step(); chk_head0("halt6", 1'b0, 32'h0, 32'h0, 32'h10);
    Redirect = 1'b1; RedirectPC = 32'h0;
    step(); chk_head0("halt7", 1'b0, 32'h0, 32'h0, 32'h0);
    chk("halt7.halted", {31'd0, halted0}, 32'd0);
    Redirect = 1'b0;
    step(); chk_head0("halt8", 1'b1, 32'h0, 32'd0, 32'h4);
`else
    chk("halt4.halted", {31'd0, halted0}, 32'd0);
    step(); chk_head0("halt5", 1'b1, 32'h10, 32'd12, 32'h14);
    chk("halt5.halted", {31'd0, halted0}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
